// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU memory stage and a word-addressed data RAM.
// Handles byte/halfword/word accesses with read-modify-write sub-word stores and load extension.
module mem_access_unit #(
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [31:0]         addr,
  input  logic [DATA_WID-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic                misalign,
  output logic [DATA_WID-1:0] rdata,
  output logic                ram_write,
  output logic [ADDR_WID-1:0] ram_addr,
  output logic [DATA_WID-1:0] ram_din,
  input  logic [DATA_WID-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t state, next_state;

  logic        we_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic                bad_req;
  logic                word_store;
  logic [4:0]          byte_sh;
  logic [4:0]          half_sh;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [DATA_WID-1:0] load_val;
  logic [DATA_WID-1:0] merged;

  // Address bits above the RAM word index wrap and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_WID+2];

  assign bad_req = (size == 2'b11)
                 | ((size == 2'b01) & addr[0])
                 | ((size == 2'b10) & (|addr[1:0]));
  assign word_store = we & (size == 2'b10);

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE) | (state == S_FAULT);
  assign misalign = (state == S_FAULT);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (bad_req)         next_state = S_FAULT;
          else if (word_store) next_state = S_WRITE;
          else                 next_state = S_READ;
        end
      end
      S_READ:  next_state = we_q ? S_WRITE : S_DONE;
      S_WRITE: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      S_FAULT: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Lane selection works directly on ram_dout, which is valid during READ
  // because ram_addr was registered at acceptance.
  always_comb begin
    byte_sh   = {off_q, 3'b000};
    half_sh   = {off_q[1], 4'b0000};
    byte_lane = ram_dout[byte_sh +: 8];
    half_lane = ram_dout[half_sh +: 16];

    case (size_q)
      2'b00:   load_val = {{(DATA_WID-8){sign_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{(DATA_WID-16){sign_q & half_lane[15]}}, half_lane};
      default: load_val = ram_dout;
    endcase

    merged = ram_dout;
    if (size_q == 2'b00) merged[byte_sh +: 8]  = wdata_q[7:0];
    else                 merged[half_sh +: 16] = wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      state     <= next_state;
      ram_write <= (next_state == S_WRITE);
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q     <= we;
            sign_q   <= sign_ext;
            size_q   <= size;
            off_q    <= addr[1:0];
            wdata_q  <= wdata[15:0];
            ram_addr <= addr[ADDR_WID+1:2];
            if (!bad_req && word_store) ram_din <= wdata;
          end
        end
        S_READ: begin
          if (we_q) ram_din <= merged;
          else      rdata   <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a negedge-write, async-read RAM model.
module tb_mem_access_unit;

  localparam int DATA_WID = 32;
  localparam int ADDR_WID = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req = 1'b0;
  logic                we = 1'b0;
  logic [1:0]          size = 2'b00;
  logic                sign_ext = 1'b0;
  logic [31:0]         addr = '0;
  logic [DATA_WID-1:0] wdata = '0;
  logic                busy, done, misalign;
  logic [DATA_WID-1:0] rdata;
  logic                ram_write;
  logic [ADDR_WID-1:0] ram_addr;
  logic [DATA_WID-1:0] ram_din;
  logic [DATA_WID-1:0] ram_dout;

  logic [DATA_WID-1:0] mem [0:(1<<ADDR_WID)-1];
  int unsigned wr_count = 0;
  int unsigned done_count = 0;
  logic [ADDR_WID-1:0] last_waddr = '0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  mem_access_unit #(.DATA_WID(DATA_WID), .ADDR_WID(ADDR_WID)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
    .rdata(rdata), .ram_write(ram_write), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];

  always @(negedge clk) begin
    if (ram_write) begin
      mem[ram_addr] = ram_din;
      last_waddr    = ram_addr;
      wr_count++;
    end
    if (done) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic w, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input logic exp_mis);
    int lat;
    int unsigned wc0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = d;
    wc0 = wr_count;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " misalign"}, {31'b0, misalign}, {31'b0, exp_mis});
    check({tag, " busy_with_done"}, {31'b0, busy}, 32'd1);
    check({tag, " writes"}, wr_count - wc0, (w && !exp_mis) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, " busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, " done_after"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned wc0, dc0;
    for (int i = 0; i < (1 << ADDR_WID); i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst misalign", {31'b0, misalign}, 32'd0);
    check("rst rdata", rdata, 32'h0);
    check("rst ram_write", {31'b0, ram_write}, 32'd0);
    check("rst ram_addr", {22'b0, ram_addr}, 32'd0);
    check("rst ram_din", ram_din, 32'h0);
    rst = 1'b0;

    do_op("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0);
    check("sw waddr", {22'b0, last_waddr}, 32'd4);
    check("sw mem", mem[4], 32'hDEADBEEF);
    do_op("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0);
    check("lw rdata", rdata, 32'hDEADBEEF);

    mem[4] = 32'h11223344;
    do_op("sb", 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, 3, 1'b0);
    check("sb mem", mem[4], 32'h11AA3344);

    do_op("lb", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 2, 1'b0);
    check("lb rdata", rdata, 32'hFFFFFFAA);
    do_op("lbu", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 2, 1'b0);
    check("lbu rdata", rdata, 32'h000000AA);
    do_op("lh", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0);
    check("lh rdata", rdata, 32'h000011AA);
    do_op("lb3", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0);
    check("lb3 rdata", rdata, 32'h00000011);

    do_op("sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h12348001, 3, 1'b0);
    check("sh mem", mem[4], 32'h80013344);
    do_op("lh_neg", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0);
    check("lh_neg rdata", rdata, 32'hFFFF8001);
    do_op("lhu", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0);
    check("lhu rdata", rdata, 32'h00003344);

    do_op("f_lw", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 1'b1);
    check("f_lw rdata", rdata, 32'h00003344);
    do_op("f_sh", 1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 1, 1'b1);
    check("f_sh mem", mem[4], 32'h80013344);
    do_op("f_sz", 1'b1, 2'b11, 1'b0, 32'h10, 32'h77777777, 1, 1'b1);
    check("f_sz mem", mem[4], 32'h80013344);
    check("f_sz rdata", rdata, 32'h00003344);

    // Handshake: req held high for nine cycles; word stores repeat every 3 cycles.
    @(negedge clk);
    wc0 = wr_count; dc0 = done_count;
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
    addr = 32'h1000_0010; wdata = 32'hCAFEF00D;
    repeat (9) @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 8 && busy; c++) @(negedge clk);
    check("hs idle", {31'b0, busy}, 32'd0);
    check("hs writes", wr_count - wc0, 32'd3);
    check("hs dones", done_count - dc0, 32'd3);
    check("hs waddr", {22'b0, last_waddr}, 32'd4);
    check("hs mem", mem[4], 32'hCAFEF00D);

    // Reset during the READ cycle of a byte store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h12; wdata = 32'h99;
    wc0 = wr_count; dc0 = done_count;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("rmo busy_read", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rmo busy", {31'b0, busy}, 32'd0);
    check("rmo done", {31'b0, done}, 32'd0);
    check("rmo rdata", rdata, 32'h0);
    check("rmo ram_write", {31'b0, ram_write}, 32'd0);
    check("rmo ram_addr", {22'b0, ram_addr}, 32'd0);
    check("rmo ram_din", ram_din, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rmo writes", wr_count - wc0, 32'd0);
    check("rmo dones", done_count - dc0, 32'd0);
    check("rmo mem", mem[4], 32'hCAFEF00D);

    do_op("lw_post", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0);
    check("lw_post rdata", rdata, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the CPU memory stage and the word-addressed data RAM (negedge write, asynchronous read). It converts byte-addressed load/store requests of byte, halfword or word size into RAM word accesses. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended, and misaligned or illegal-size requests are rejected without touching memory. It runs a small FSM with a req/busy/done handshake toward the CPU and drives the RAM's write, address and data ports directly.

## Interface
- DATA_WID, 32, data word width; fixed at 32, since byte-lane logic assumes 4 lanes.
- ADDR_WID, 10, RAM word-address width.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  1 = sign-extend sub-word loads; ignored for stores and words.
- addr  in  32  byte address.
- wdata  in  32  store data; the value is taken from the low bits for byte/half.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  valid with done; 1 = request rejected.
- rdata  out  32  load result; updated only by a successful load.
- ram_write  out  1  RAM write enable; registered.
- ram_addr  out  ADDR_WID  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data; combinational from ram_addr.

## Operation
- Word index is addr[ADDR_WID+1:2]. Bits above ADDR_WID+1 are ignored, so addresses wrap modulo 4*2^ADDR_WID bytes.
- Little-endian lanes:
  - byte offset k selects bits 8k+7:8k;
  - halfword offset 0 selects bits 15:0, offset 2 selects bits 31:16.
- Alignment rules:
  - a halfword needs addr[0]=0;
  - a word needs addr[1:0]=00;
  - size=11 always faults.
- FSM states: IDLE, READ, WRITE, DONE, FAULT.
- IDLE, req=1: latch we, size, sign_ext, addr, wdata; drive ram_addr from the latched word index. Next state:
  - FAULT if misaligned or size=11;
  - WRITE for a word store (ram_din=wdata, ram_write=1);
  - READ otherwise.
- READ: capture ram_dout into an internal buffer.
  - Load: rdata gets the extracted lane. sign_ext=1 replicates the lane MSB into the upper bits; otherwise the upper bits are zero. Next state DONE.
  - Sub-word store: ram_din gets the buffer with the target lane replaced by wdata[7:0] or wdata[15:0]. ram_write=1. Next state WRITE.
- WRITE: ram_write is held high for the whole cycle, so the RAM commits at the mid-cycle negedge. Next state DONE; ram_write clears.
- DONE: done=1, misalign=0. Next state IDLE.
- FAULT: done=1, misalign=1. rdata and RAM are untouched; ram_write is never asserted. Next state IDLE.
- req outside IDLE is ignored; requests are not queued. The CPU must hold or re-issue req until it sees busy=0.

## Timing
- Reset values: state IDLE, busy 0, done 0, misalign 0, rdata 0, ram_write 0, ram_addr 0, ram_din 0.
- Latency is measured from the posedge that accepts req (edge 0) to the cycle where done is high:
  - load: 2 cycles (READ, DONE);
  - word store: 2 cycles (WRITE, DONE);
  - byte/half store: 3 cycles (READ, WRITE, DONE);
  - fault: 1 cycle (FAULT).
- Exactly one RAM write per store, landing on the negedge inside the WRITE cycle. ram_addr and ram_din are stable for that entire cycle.
- busy rises the cycle after acceptance and falls together with done's trailing edge. The earliest next acceptance is the posedge ending the DONE/FAULT cycle.
- Throughput is at most one request per 3 cycles (load) or 4 cycles (sub-word store).
- rst asserted mid-operation:
  - ram_write drops immediately and the state returns to IDLE;
  - if this happens before the WRITE negedge, no write occurs;
  - done is not pulsed for the aborted request.
- A read-modify-write is not atomic against other RAM masters; this block is the only RAM master.

## Test plan
- Reset, then a word store: sw addr=0x10, wdata=0xDEADBEEF. Expect ram_write high for exactly 1 cycle with ram_addr=4, then done 2 cycles after acceptance. A following lw addr=0x10 returns rdata=0xDEADBEEF.
- Byte store RMW: preload word 4 with 0x11223344; sb addr=0x12, wdata=0xAA. Expect word 4 = 0x11AA3344 and done 3 cycles after acceptance.
- Extension: word 4 = 0x11AA3344.
  - lb addr=0x12 with sign_ext=1 returns 0xFFFFFFAA;
  - lbu (sign_ext=0) returns 0x000000AA;
  - lh addr=0x12 with sign_ext=1 returns 0x000011AA.
- Faults: lw addr=0x13, sh addr=0x11, and size=11 each give done=1, misalign=1 one cycle after acceptance. ram_write never rises, memory is unchanged, and rdata holds its previous value.
- Handshake: assert req continuously while busy. Only one access occurs per DONE; address wrap-around holds, e.g. sw addr=0x1000_0010 writes word 4 when ADDR_WID=10.
- Reset mid-op: assert rst during READ of sb addr=0x12. Memory is unchanged, all outputs return to their reset values, and done is not pulsed.
